bus_dest_decoder: RTL and testbench

//  Write side of the CPU datapath bus. It takes a 5-bit destination code plus valid from the control unit
//  and decodes it into a registered one-hot load-enable vector. The code map is the same one the bus

---
 rtl/bus_dest_decoder.sv | 123 ++++++++++++
 tb/tb_bus_dest_decoder.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_dest_decoder.sv
`default_nettype none
// ============================================================================
//  Module  : bus_dest_decoder
//  Purpose : Write side of the datapath bus. Decodes a 5-bit destination code
//            into a registered one-hot load-enable vector and captures the
//            bus value in the same edge, so that the destination register,
//            its enable and its data all arrive together. Illegal codes drop
//            the block into a sticky ERROR state until ErrClr.
//  Ports   :
//    clk_i           datapath clock, rising edge
//    rst_ni          asynchronous active-low reset
//    dest_code_i     destination code (0..NUM_DEST-1 legal)
//    dest_valid_i    write request this cycle
//    hold_i          stall, blocks acceptance
//    err_clr_i       clears ERROR state and illegal_dest_o
//    bus_mux_out_i   current bus value
//    dest_ready_o    request accepted when dest_valid_i & dest_ready_o
//    load_en_o       registered one-hot load enables
//    bus_latch_o     bus value captured with the accepted write
//    illegal_dest_o  sticky illegal-code flag
//    write_count_o   count of legal accepted writes (wraps)
//  Revision: 1.0 - initial release
// ============================================================================
module bus_dest_decoder #(
  parameter int NUM_DEST = 24,
  parameter int CNT_W    = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [4:0]          dest_code_i,
  input  logic                dest_valid_i,
  input  logic                hold_i,
  input  logic                err_clr_i,
  input  logic [31:0]         bus_mux_out_i,
  output logic                dest_ready_o,
  output logic [NUM_DEST-1:0] load_en_o,
  output logic [31:0]         bus_latch_o,
  output logic                illegal_dest_o,
  output logic [CNT_W-1:0]    write_count_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_ERROR = 2'd2
  } state_e;

  // Extra bit so that NUM_DEST = 32 is representable; with 32 destinations
  // every 5-bit code compares legal and the ERROR path can never be entered.
  localparam logic [5:0]          C_NUM_DEST = 6'(NUM_DEST);
  localparam logic [NUM_DEST-1:0] C_ONE      = NUM_DEST'(1);

  state_e              state_q, state_d;
  logic [NUM_DEST-1:0] load_en_q, load_en_d;
  logic [31:0]         bus_latch_q, bus_latch_d;
  logic                illegal_q, illegal_d;
  logic [CNT_W-1:0]    count_q, count_d;

  logic w_accept;
  logic w_legal;

  assign dest_ready_o = !hold_i && (state_q != ST_ERROR);
  assign w_accept     = dest_valid_i && dest_ready_o;
  assign w_legal      = ({1'b0, dest_code_i} < C_NUM_DEST);

  always_comb begin
    state_d     = state_q;
    load_en_d   = '0;
    bus_latch_d = bus_latch_q;
    illegal_d   = illegal_q;
    count_d     = count_q;

    case (state_q)
      ST_ERROR: begin
        // dest_ready_o is low here, so no request can be accepted.
        if (err_clr_i) begin
          state_d   = ST_IDLE;
          illegal_d = 1'b0;
        end
      end
      default: begin
        if (err_clr_i) begin
          illegal_d = 1'b0;
        end
        if (w_accept && w_legal) begin
          state_d     = ST_WRITE;
          load_en_d   = C_ONE << dest_code_i;
          bus_latch_d = bus_mux_out_i;
          count_d     = count_q + CNT_W'(1);
        end else if (w_accept) begin
          // Setting the flag takes priority over a same-cycle ErrClr.
          state_d   = ST_ERROR;
          illegal_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      load_en_q   <= '0;
      bus_latch_q <= '0;
      illegal_q   <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      load_en_q   <= load_en_d;
      bus_latch_q <= bus_latch_d;
      illegal_q   <= illegal_d;
      count_q     <= count_d;
    end
  end

  assign load_en_o      = load_en_q;
  assign bus_latch_o    = bus_latch_q;
  assign illegal_dest_o = illegal_q;
  assign write_count_o  = count_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_dest_decoder.sv
`default_nettype none
// ============================================================================
//  Module  : tb_bus_dest_decoder
//  Purpose : Self-checking bench for bus_dest_decoder. Stimulus pushes the
//            reference model's expected registered outputs into a queue; an
//            independent monitor pops one entry per clock edge and compares.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_bus_dest_decoder;

  localparam int NUM_DEST = 24;
  localparam int CNT_W    = 16;

  logic                clk;
  logic                rst_n;
  logic [4:0]          dest_code;
  logic                dest_valid;
  logic                hold;
  logic                err_clr;
  logic [31:0]         bus_in;
  logic                dest_ready;
  logic [NUM_DEST-1:0] load_en;
  logic [31:0]         bus_latch;
  logic                illegal_dest;
  logic [CNT_W-1:0]    write_count;

  bus_dest_decoder #(.NUM_DEST(NUM_DEST), .CNT_W(CNT_W)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .dest_code_i    (dest_code),
    .dest_valid_i   (dest_valid),
    .hold_i         (hold),
    .err_clr_i      (err_clr),
    .bus_mux_out_i  (bus_in),
    .dest_ready_o   (dest_ready),
    .load_en_o      (load_en),
    .bus_latch_o    (bus_latch),
    .illegal_dest_o (illegal_dest),
    .write_count_o  (write_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [NUM_DEST-1:0] le;
    logic [31:0]         latch;
    logic [CNT_W-1:0]    cnt;
    logic                ill;
  } exp_t;

  exp_t exp_q[$];

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: plain abstract state of the block.
  bit               m_err;
  bit               m_ill;
  logic [31:0]      m_latch;
  logic [CNT_W-1:0] m_cnt;

  task automatic model_reset();
    m_err   = 0;
    m_ill   = 0;
    m_latch = '0;
    m_cnt   = '0;
  endtask

  // One clock of stimulus: drive at the falling edge, check ready, then
  // predict what the registered outputs will show after the next rising edge.
  task automatic cyc(input bit v, input logic [4:0] code, input bit h,
                     input bit ec, input logic [31:0] bus);
    bit    exp_rdy;
    bit    acc;
    exp_t  e;
    int    c;
    @(negedge clk);
    dest_valid = v;
    dest_code  = code;
    hold       = h;
    err_clr    = ec;
    bus_in     = bus;
    #1;
    exp_rdy = !h && !m_err;
    n_cmp++;
    if (dest_ready !== exp_rdy) begin
      n_err++;
      $display("FAIL ready: got %b expected %b (code %0d hold %b)", dest_ready, exp_rdy, code, h);
    end
    acc  = v && exp_rdy;
    c    = int'(code);
    e.le = '0;
    if (m_err) begin
      if (ec) begin
        m_err = 0;
        m_ill = 0;
      end
    end else begin
      if (ec) m_ill = 0;
      if (acc && c < NUM_DEST) begin
        e.le    = NUM_DEST'(1) << c;
        m_latch = bus;
        m_cnt   = m_cnt + 1'b1;
      end else if (acc) begin
        m_err = 1;
        m_ill = 1;
      end
    end
    e.latch = m_latch;
    e.cnt   = m_cnt;
    e.ill   = m_ill;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 5'd0, 0, 0, 32'h0);
  endtask

  // Monitor: every rising edge presents one registered result.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (load_en !== e.le || bus_latch !== e.latch ||
            write_count !== e.cnt || illegal_dest !== e.ill) begin
          n_err++;
          $display("FAIL sb: got le=%h latch=%h cnt=%h ill=%b expected le=%h latch=%h cnt=%h ill=%b",
                   load_en, bus_latch, write_count, illegal_dest, e.le, e.latch, e.cnt, e.ill);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  initial begin
    int wait_cnt;
    rst_n      = 1'b0;
    dest_valid = 1'b0;
    dest_code  = '0;
    hold       = 1'b0;
    err_clr    = 1'b0;
    bus_in     = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_le", 64'(load_en), 64'd0);
    chk("reset_latch", 64'(bus_latch), 64'd0);
    chk("reset_cnt", 64'(write_count), 64'd0);
    chk("reset_ill", 64'(illegal_dest), 64'd0);
    chk("reset_ready", 64'(dest_ready), 64'd1);
    rst_n = 1'b1;

    // Single write.
    cyc(1, 5'd5, 0, 0, 32'hDEADBEEF);
    idle(2);
    // Back-to-back, same bit twice.
    cyc(1, 5'd20, 0, 0, 32'hAAAA0001);
    cyc(1, 5'd21, 0, 0, 32'hBBBB0002);
    cyc(1, 5'd21, 0, 0, 32'hCCCC0003);
    idle(1);
    // Illegal code, ignored request, clear, then accepted.
    cyc(1, 5'd27, 0, 0, 32'h11111111);
    cyc(1, 5'd3, 0, 0, 32'h22222222);
    cyc(1, 5'd3, 0, 1, 32'h33333333);
    cyc(1, 5'd3, 0, 0, 32'h44444444);
    idle(1);
    // Hold blocks acceptance; release accepts. Hold right after a write.
    cyc(1, 5'd1, 1, 0, 32'h55555555);
    cyc(1, 5'd1, 1, 0, 32'h55555555);
    cyc(1, 5'd1, 0, 0, 32'h66666666);
    cyc(1, 5'd2, 1, 0, 32'h77777777);
    // Boundary codes 23 (last legal), 24 (first illegal), 31.
    cyc(1, 5'd23, 0, 0, 32'h88888888);
    cyc(1, 5'd24, 0, 0, 32'h99999999);
    cyc(0, 5'd0, 0, 1, 32'h0);
    cyc(1, 5'd31, 0, 0, 32'h12345678);
    cyc(0, 5'd0, 0, 1, 32'h0);
    cyc(1, 5'd0, 0, 0, 32'hCAFEF00D);
    idle(1);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      bit          v, h, ec;
      logic [4:0]  code;
      v    = ($urandom_range(0, 3) != 0);
      h    = ($urandom_range(0, 4) == 0);
      ec   = m_err ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
      code = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(24, 31))
                                         : 5'($urandom_range(0, 23));
      cyc(v, code, h, ec, $urandom);
    end
    cyc(0, 5'd0, 0, 1, 32'h0);
    idle(1);

    // Counter wrap: drive it to all-ones then one more write.
    while (m_cnt != {CNT_W{1'b1}}) cyc(1, 5'($urandom_range(0, 23)), 0, 0, $urandom);
    cyc(1, 5'd9, 0, 0, 32'h0BADC0DE);
    idle(1);

    // Asynchronous reset while a write is showing.
    cyc(1, 5'd7, 0, 0, 32'hFEEDFACE);
    @(negedge clk);
    dest_valid = 1'b0;
    @(posedge clk);
    #3;
    n_cmp++;
    if (load_en !== '0 || bus_latch !== 32'hFEEDFACE) begin
      n_err++;
      $display("FAIL pre_areset: got le=%h latch=%h expected le=0 latch=feedface", load_en, bus_latch);
    end
    dest_valid = 1'b0;
    idle(0);
    rst_n = 1'b0;
    #1;
    // Write issued just before the reset so the enable is live when it hits.
    rst_n = 1'b1;
    model_reset();
    cyc(1, 5'd7, 0, 0, 32'hFEEDFACE);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("areset_le", 64'(load_en), 64'd0);
    chk("areset_latch", 64'(bus_latch), 64'd0);
    chk("areset_cnt", 64'(write_count), 64'd0);
    model_reset();
    dest_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1, 5'd12, 0, 0, 32'h13572468);
    idle(2);

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 100) begin
      @(negedge clk);
      wait_cnt++;
    end
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d entries left expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
